uart_tx_arbiter: RTL and testbench

Shares one UART byte transmitter among NUM_REQ requesters (debug console, status reporter, loopback echo, etc.).
- Arbitration is round-robin per packet: a granted requester keeps the transmitter until its byte flagged last has gone out.
- Sequences the transmitter over a tx_start / tx_busy handshake, one byte at a time, and detects a transmitter that never starts.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART byte transmitter among NUM_REQ requesters. Ownership is
// granted round-robin per packet: the winner keeps the transmitter until its
// byte flagged last has been sent. Bytes are handed over one at a time on a
// tx_start / tx_busy handshake. A transmitter that never raises tx_busy after
// a start aborts the packet and raises err_timeout.
//
// Ports
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester byte available
//   req_data      byte of requester i on bits [8i+7:8i]
//   req_last      byte of requester i ends its packet
//   req_ready     one-hot, byte of requester i consumed this cycle
//   tx_data       byte presented to the transmitter, held until the next load
//   tx_start      one-cycle pulse starting transmission of tx_data
//   tx_busy       transmitter busy
//   grant_active  a requester currently owns the transmitter
//   grant_id      owning requester, holds its last value when idle
//   err_timeout   one-cycle pulse when a start timeout aborts a packet
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              grant_active_q;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              err_timeout_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              win_found;
  logic [ID_W-1:0]   win_id;

  // Successor of a requester index with wrap at NUM_REQ-1 (NUM_REQ need not
  // be a power of two, so plain ID_W overflow is not enough).
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Round-robin pick: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Only the owner may hand over a byte, and only while fetching.
  always_comb begin
    req_ready = '0;
    if (state_q == FETCH) begin
      req_ready[grant_id_q] = req_valid[grant_id_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      last_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_id_q     <= win_id;
            grant_active_q <= 1'b1;
            state_q        <= FETCH;
          end
        end

        // The grant stays locked here even if the owner goes quiet.
        FETCH: begin
          if (req_valid[grant_id_q]) begin
            tx_data_q  <= req_data[int'(grant_id_q)*8 +: 8];
            last_q     <= req_last[grant_id_q];
            tx_start_q <= 1'b1;   // high for exactly the START cycle
            state_q    <= START;
          end
        end

        // tx_busy is deliberately not looked at here.
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT_HI;
        end

        WAIT_HI: begin
          if (tx_busy) begin
            state_q <= WAIT_LO;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            err_timeout_q  <= 1'b1;
            grant_active_q <= 1'b0;
            rr_ptr_q       <= next_id(grant_id_q);
            state_q        <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q) begin
              grant_active_q <= 1'b0;
              rr_ptr_q       <= next_id(grant_id_q);
              state_q        <= IDLE;
            end else begin
              state_q <= FETCH;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Requesters are per-index byte FIFOs
// that present their head byte; a simple transmitter model raises tx_busy two
// cycles after each start and holds it for twenty cycles (or never, when
// tx_dead is set). Inputs change on negedge; outputs are sampled at
// negedge+2 by the directed sequence and at negedge+4 by the monitor.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int ID_W          = 2;
  localparam int START_TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy = 1'b0;
  logic                 grant_active;
  logic [ID_W-1:0]      grant_id;
  logic                 err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester FIFOs: {last, data}
  logic [8:0] pkt_mem [NUM_REQ][32];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];

  // Transmitter model
  bit tx_dead    = 1'b0;
  int dly        = 0;
  int blen       = 0;
  int busy_delay = 2;
  int busy_len   = 20;

  // Monitor logs
  logic [7:0] log_data [64];
  int         log_id   [64];
  int         log_n    = 0;
  int         to_cnt   = 0;
  int         ready_cnt [NUM_REQ];

  // Scratch for the directed sequence
  int k;
  int cyc;
  int base_to;
  int base_rdy;
  bit locked;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_active(grant_active),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pkt_mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int w;
    w = 0;
    while (!(log_n >= n && !grant_active) && w < budget) begin
      step();
      w++;
    end
    check({tag, "_done"}, 32'(log_n >= n && !grant_active), 1);
  endtask

  // Requester drive, transmitter model and output monitor.
  always begin
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = pkt_mem[i][head[i]][7:0];
        req_last[i]        = pkt_mem[i][head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    if (!rst_n) begin
      tx_busy = 1'b0;
      dly     = 0;
      blen    = 0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        tx_busy = 1'b1;
        blen    = busy_len;
      end
    end else if (blen > 0) begin
      blen--;
      if (blen == 0) tx_busy = 1'b0;
    end
    #4;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        head[i]++;
        ready_cnt[i]++;
      end
    end
    if (tx_start) begin
      if (log_n < 64) begin
        log_data[log_n] = tx_data;
        log_id[log_n]   = int'(grant_id);
      end
      log_n++;
      if (!tx_dead) dly = busy_delay;
    end
    if (err_timeout) to_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i]      = 0;
      tail[i]      = 0;
      ready_cnt[i] = 0;
    end

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_grant_active", 32'(grant_active), 0);
    check("rst_grant_id",     32'(grant_id), 0);
    check("rst_tx_start",     32'(tx_start), 0);
    check("rst_tx_data",      32'(tx_data), 0);
    check("rst_err_timeout",  32'(err_timeout), 0);
    check("rst_req_ready",    32'(req_ready), 0);
    check("rst_rr_ptr",       32'(dut.rr_ptr_q), 0);
    rst_n = 1'b1;
    step();

    // ---------------- 1: single requester, 3-byte packet ----------------
    log_n = 0;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    step();
    check("t1_no_grant_yet", 32'(grant_active), 0);
    step();
    check("t1_grant_active", 32'(grant_active), 1);
    check("t1_grant_id",     32'(grant_id), 0);
    check("t1_req_ready",    32'(req_ready), 32'b0001);
    step();
    check("t1_tx_start",     32'(tx_start), 1);
    check("t1_tx_data0",     32'(tx_data), 32'h41);
    check("t1_ready_drop",   32'(req_ready), 0);
    step();
    check("t1_start_one_cycle", 32'(tx_start), 0);
    wait_done("t1", 3, 300);
    check("t1_byte_count", log_n, 3);
    check("t1_tx_data1",   32'(log_data[1]), 32'h42);
    check("t1_tx_data2",   32'(log_data[2]), 32'h43);
    check("t1_rr_ptr",     32'(dut.rr_ptr_q), 1);

    // ---------------- 2: req1 and req2 together from reset ----------------
    rst_n = 1'b0;
    log_n = 0;
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b1);
    push(2, 8'hB1, 1'b0);
    push(2, 8'hB2, 1'b1);
    step();
    rst_n = 1'b1;
    wait_done("t2", 4, 400);
    check("t2_id0",   log_id[0], 1);
    check("t2_id1",   log_id[1], 1);
    check("t2_id2",   log_id[2], 2);
    check("t2_id3",   log_id[3], 2);
    check("t2_data0", 32'(log_data[0]), 32'hA1);
    check("t2_data1", 32'(log_data[1]), 32'hA2);
    check("t2_data2", 32'(log_data[2]), 32'hB1);
    check("t2_data3", 32'(log_data[3]), 32'hB2);
    check("t2_rr_ptr", 32'(dut.rr_ptr_q), 3);

    // ---------------- 3: rr_ptr=3, req0 and req3 together ----------------
    log_n = 0;
    push(0, 8'hC1, 1'b1);
    push(3, 8'hD1, 1'b1);
    wait_done("t3", 2, 200);
    check("t3_first_id",    log_id[0], 3);
    check("t3_second_id",   log_id[1], 0);
    check("t3_first_data",  32'(log_data[0]), 32'hD1);
    check("t3_second_data", 32'(log_data[1]), 32'hC1);
    check("t3_rr_ptr",      32'(dut.rr_ptr_q), 1);

    // ---------------- 4: transmitter never starts ----------------
    tx_dead  = 1'b1;
    log_n    = 0;
    base_to  = to_cnt;
    base_rdy = ready_cnt[0];
    push(0, 8'h55, 1'b1);
    k = 0;
    while (!tx_start && k < 20) begin
      step();
      k++;
    end
    check("t4_start_seen", 32'(tx_start), 1);
    check("t4_tx_data",    32'(tx_data), 32'h55);
    cyc = 0;
    while (!err_timeout && cyc < 200) begin
      step();
      cyc++;
    end
    check("t4_timeout_latency", cyc, 65);
    check("t4_grant_released",  32'(grant_active), 0);
    step();
    check("t4_err_one_cycle",   32'(err_timeout), 0);
    repeat (30) step();
    check("t4_err_pulse_count", to_cnt - base_to, 1);
    check("t4_no_more_ready",   ready_cnt[0] - base_rdy, 1);
    check("t4_still_idle",      32'(grant_active), 0);
    tx_dead = 1'b0;

    // ---------------- 5: owner pauses mid-packet ----------------
    log_n    = 0;
    base_rdy = ready_cnt[2];
    push(1, 8'hE1, 1'b0);
    push(2, 8'hF1, 1'b1);
    k = 0;
    while (log_n < 1 && k < 50) begin
      step();
      k++;
    end
    check("t5_first_owner", log_id[0], 1);
    locked = 1'b1;
    repeat (30) begin
      step();
      if (!(grant_active && grant_id == 2'd1)) locked = 1'b0;
    end
    check("t5_grant_locked", 32'(locked), 1);
    check("t5_req2_waits",   ready_cnt[2] - base_rdy, 0);
    check("t5_no_extra_tx",  log_n, 1);
    push(1, 8'hE2, 1'b1);
    wait_done("t5", 3, 300);
    check("t5_id1",   log_id[1], 1);
    check("t5_data1", 32'(log_data[1]), 32'hE2);
    check("t5_id2",   log_id[2], 2);
    check("t5_data2", 32'(log_data[2]), 32'hF1);

    // ---------------- 6: reset during WAIT_LO ----------------
    log_n   = 0;
    base_to = to_cnt;
    push(3, 8'h61, 1'b0);
    push(3, 8'h62, 1'b0);
    push(3, 8'h63, 1'b1);
    k = 0;
    while (!tx_busy && k < 50) begin
      step();
      k++;
    end
    step();
    step();
    check("t6_in_flight", 32'(grant_active), 1);
    check("t6_owner",     32'(grant_id), 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant_active", 32'(grant_active), 0);
    check("t6_rst_grant_id",     32'(grant_id), 0);
    check("t6_rst_tx_data",      32'(tx_data), 0);
    check("t6_rst_tx_start",     32'(tx_start), 0);
    check("t6_rst_err",          32'(err_timeout), 0);
    check("t6_rst_rr_ptr",       32'(dut.rr_ptr_q), 0);
    head[3] = tail[3];
    log_n   = 0;
    push(1, 8'h71, 1'b1);
    push(3, 8'h73, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    wait_done("t6", 2, 200);
    check("t6_first_after_rst",  log_id[0], 1);
    check("t6_second_after_rst", log_id[1], 3);
    check("t6_no_err_pulse",     to_cnt - base_to, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
